// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants, state encoding and lane helpers for the unified memory port arbiter.
package mem_arb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_RMW_WR = 1'b1
  } arb_state_e;

  // Encoding 2'b11 is folded into word so every size decodes to a defined width.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  function automatic logic lane_from_new(input logic [1:0] size, input int lane);
    case (size)
      SIZE_BYTE: return (lane == 0);
      SIZE_HALF: return (lane < 2);
      SIZE_WORD: return 1'b1;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and memory-side signals of the arbiter, with arbiter (slave) and environment (master) views.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4
);
  import mem_arb_pkg::*;

  localparam int DW = BYTE_SIZE * 8;

  // Handshake: a requester raises req with a stable payload and keeps both
  // unchanged until gnt is seen high at a rising edge; that edge completes the
  // transfer. rvalid is a single-cycle pulse on the cycle after a read grant.
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DW-1:0]         if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [1:0]            d_size;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DW-1:0]         d_wdata;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DW-1:0]         d_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DW-1:0]         mem_wd;
  logic [DW-1:0]         mem_rd;

  arb_state_e            dbg_state;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rd,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_addr, mem_we, mem_wd, dbg_state
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, mem_rd,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_addr, mem_we, mem_wd, dbg_state
  );

endinterface

// File: rtl/mem_port_arbiter_byte_lane_merge.sv
// Replaces the low 1, 2 or all byte lanes of old_word with those of new_data.
// With old_word tied to zero this is a zero-extending load mask.
module byte_lane_merge
  import mem_arb_pkg::*;
#(
  parameter int BYTE_SIZE = 4
) (
  input  logic [BYTE_SIZE*8-1:0] old_word,
  input  logic [BYTE_SIZE*8-1:0] new_data,
  input  logic [1:0]             size,
  output logic [BYTE_SIZE*8-1:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < BYTE_SIZE; i++) begin
      if (lane_from_new(size, i)) begin
        merged[i*8 +: 8] = new_data[i*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single combinational-read / synchronous-write memory between fetch and
// load/store, registering read data and splitting sub-word stores into read-modify-write.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int BYTE_SIZE  = 4,
  parameter int MAX_STREAK = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int DW = BYTE_SIZE * 8;
  localparam int CW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
  localparam logic [CW-1:0] STREAK_MAX = CW'((MAX_STREAK < 1) ? 1 : MAX_STREAK);

  arb_state_e            state_q, state_d;
  logic [CW-1:0]         starve_cnt_q, starve_cnt_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]         if_rdata_q, if_rdata_d;
  logic [DW-1:0]         d_rdata_q, d_rdata_d;
  logic [DW-1:0]         merge_q, merge_d;

  logic                  fetch_wins;
  logic                  if_gnt_c;
  logic                  d_gnt_c;
  logic                  mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DW-1:0]         mem_wd_c;
  logic [DW-1:0]         lane_old;
  logic [DW-1:0]         lane_new;
  logic [DW-1:0]         lane_out;

  assign fetch_wins = bus.if_req && (!bus.d_req || (starve_cnt_q == STREAK_MAX));

  // One merger serves both directions: stores patch the fetched word with
  // d_wdata, loads patch a zero word with the memory data.
  assign lane_old = bus.d_we ? bus.mem_rd  : '0;
  assign lane_new = bus.d_we ? bus.d_wdata : bus.mem_rd;

  byte_lane_merge #(
    .BYTE_SIZE(BYTE_SIZE)
  ) u_merge (
    .old_word(lane_old),
    .new_data(lane_new),
    .size    (bus.d_size),
    .merged  (lane_out)
  );

  always_comb begin
    state_d     = state_q;
    if_gnt_c    = 1'b0;
    d_gnt_c     = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = bus.if_addr;
    mem_wd_c    = bus.d_wdata;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    merge_d     = merge_q;

    case (state_q)
      ST_ARB: begin
        if (fetch_wins) begin
          if_gnt_c    = 1'b1;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rd;
        end else if (bus.d_req) begin
          mem_addr_c = bus.d_addr;
          if (!bus.d_we) begin
            d_gnt_c    = 1'b1;
            d_rvalid_d = 1'b1;
            d_rdata_d  = lane_out;
          end else if (is_word(bus.d_size)) begin
            mem_we_c = 1'b1;
            d_gnt_c  = 1'b1;
          end else begin
            // Read phase of a sub-word store: capture the patched word, write next cycle.
            merge_d = lane_out;
            state_d = ST_RMW_WR;
          end
        end
      end
      ST_RMW_WR: begin
        mem_addr_c = bus.d_addr;
        mem_we_c   = 1'b1;
        mem_wd_c   = merge_q;
        d_gnt_c    = 1'b1;
        state_d    = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase

    if (!bus.if_req || if_gnt_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != STREAK_MAX) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      starve_cnt_q <= '0;
      if_rvalid_q  <= 1'b0;
      d_rvalid_q   <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      merge_q      <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      merge_q      <= merge_d;
    end
  end

  // Gating by rst_n keeps a reset that lands mid-RMW from committing the write.
  assign bus.if_gnt    = if_gnt_c & rst_n;
  assign bus.d_gnt     = d_gnt_c  & rst_n;
  assign bus.mem_we    = mem_we_c & rst_n;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wd    = mem_wd_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte-array memory model, read-data scoreboard, grant checks.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic rst_n;
  logic mem_load;
  logic [7:0] mem_arr [256];

  int vectors = 0;
  int fails   = 0;

  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];

  mem_port_arbiter_if #(.ADDR_WIDTH(32), .BYTE_SIZE(4)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(32),
    .BYTE_SIZE (4),
    .MAX_STREAK(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- memory model ----------------
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      bus.mem_rd[i*8 +: 8] = mem_arr[8'(bus.mem_addr[7:0] + 8'(i))];
    end
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= 8'h00;
      mem_arr[8'h00] <= 8'h11; mem_arr[8'h01] <= 8'h22;
      mem_arr[8'h02] <= 8'h33; mem_arr[8'h03] <= 8'h44;
      mem_arr[8'h10] <= 8'hAA; mem_arr[8'h11] <= 8'hBB;
      mem_arr[8'h12] <= 8'hCC; mem_arr[8'h13] <= 8'hDD;
      mem_arr[8'h14] <= 8'hEE;
    end else if (bus.mem_we) begin
      for (int i = 0; i < 4; i++) begin
        mem_arr[8'(bus.mem_addr[7:0] + 8'(i))] <= bus.mem_wd[i*8 +: 8];
      end
    end
  end

  // ---------------- check / scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    check("single_gnt", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
    if (bus.if_rvalid) begin
      if (if_exp_q.size() == 0) check("if_rvalid_extra", 32'(bus.if_rvalid), 32'd0);
      else check("if_rdata", bus.if_rdata, if_exp_q.pop_front());
    end
    if (bus.d_rvalid) begin
      if (d_exp_q.size() == 0) check("d_rvalid_extra", 32'(bus.d_rvalid), 32'd0);
      else check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req   = 1'b1;
    bus.d_we    = we;
    bus.d_size  = size;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  task automatic data_op(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp);
    logic got;
    int   cyc;
    drive_d(we, size, addr, wdata);
    if (!we) d_exp_q.push_back(exp);
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 8) begin
      @(negedge clk);
      got = bus.d_gnt;
      tick();
      cyc++;
    end
    bus.d_req = 1'b0;
    check("d_gnt_within_budget", 32'(got), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic exp_d_win [6];

  initial begin
    exp_d_win = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    rst_n = 1'b0;
    mem_load = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = SIZE_WORD; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (2) tick();
    mem_load = 1'b0;

    // Requests raised while in reset must see no grant and no write.
    bus.if_req = 1'b1;
    drive_d(1'b1, SIZE_WORD, 32'h40, 32'h12345678);
    @(negedge clk);
    check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_ARB));
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Fetch alone: granted in its first cycle.
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    if_exp_q.push_back(32'hDDCCBBAA);
    @(negedge clk);
    check("fetch_gnt_c0", 32'(bus.if_gnt), 32'd1);
    check("fetch_addr", bus.mem_addr, 32'h10);
    tick();
    bus.if_req = 1'b0;
    tick();

    // Simultaneous fetch and load: data first, then fetch.
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    drive_d(1'b0, SIZE_WORD, 32'h10, 32'h0);
    d_exp_q.push_back(32'hDDCCBBAA);
    if_exp_q.push_back(32'h44332211);
    @(negedge clk);
    check("both_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("both_if_gnt_c0", 32'(bus.if_gnt), 32'd0);
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);
    check("both_if_gnt_c1", 32'(bus.if_gnt), 32'd1);
    tick();
    bus.if_req = 1'b0;
    tick();

    // Byte store at 0x11 with fetch waiting: memory locked for both RMW cycles.
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    if_exp_q.push_back(32'h44332211);
    drive_d(1'b1, SIZE_BYTE, 32'h11, 32'h00000055);
    @(negedge clk);
    check("rmw_rd_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("rmw_rd_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rmw_rd_mem_we", 32'(bus.mem_we), 32'd0);
    check("rmw_rd_addr", bus.mem_addr, 32'h11);
    tick();
    @(negedge clk);
    check("rmw_wr_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("rmw_wr_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("rmw_wr_mem_we", 32'(bus.mem_we), 32'd1);
    check("rmw_wr_mem_wd", bus.mem_wd, 32'hEEDDCC55);
    tick();
    bus.d_req = 1'b0;
    @(negedge clk);
    check("rmw_after_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick();
    bus.if_req = 1'b0;
    data_op(1'b0, SIZE_WORD, 32'h10, 32'h0, 32'hDDCC55AA);

    // Halfword store then loads of several sizes.
    data_op(1'b1, SIZE_HALF, 32'h10, 32'h0000BEEF, 32'h0);
    data_op(1'b0, SIZE_WORD, 32'h10, 32'h0, 32'hDDCCBEEF);
    data_op(1'b0, SIZE_BYTE, 32'h12, 32'h0, 32'h000000CC);
    data_op(1'b0, SIZE_HALF, 32'h10, 32'h0, 32'h0000BEEF);
    data_op(1'b0, 2'b11,     32'h11, 32'h0, 32'hEEDDCCBE);
    data_op(1'b1, SIZE_WORD, 32'h20, 32'hCAFEF00D, 32'h0);
    data_op(1'b0, SIZE_WORD, 32'h20, 32'h0, 32'hCAFEF00D);
    tick();

    // Streak limit 2: continuous loads with fetch held -> D,D,IF,D,D,IF.
    for (int k = 0; k < 6; k++) begin
      if (exp_d_win[k]) d_exp_q.push_back(32'hDDCCBEEF);
      else if_exp_q.push_back(32'h44332211);
    end
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    drive_d(1'b0, SIZE_WORD, 32'h10, 32'h0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("streak_d_gnt", 32'(bus.d_gnt), 32'(exp_d_win[k]));
      check("streak_if_gnt", 32'(bus.if_gnt), 32'(!exp_d_win[k]));
      tick();
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    tick();

    // Reset lands during the write phase of a byte store at 0x13.
    drive_d(1'b1, SIZE_BYTE, 32'h13, 32'h00000077);
    @(negedge clk);
    check("mid_rd_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    check("mid_state_wr", 32'(bus.dbg_state), 32'(ST_RMW_WR));
    rst_n = 1'b0;
    #1;
    check("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("mid_rst_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("mid_rst_if_gnt", 32'(bus.if_gnt), 32'd0);
    check("mid_rst_if_rdata", bus.if_rdata, 32'h0);
    check("mid_rst_d_rdata", bus.d_rdata, 32'h0);
    check("mid_rst_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(ST_ARB));
    tick();
    check("mid_rst_mem13", 32'(mem_arr[8'h13]), 32'hDD);
    rst_n = 1'b1;
    @(negedge clk);
    check("restart_rd_d_gnt", 32'(bus.d_gnt), 32'd0);
    check("restart_rd_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    @(negedge clk);
    check("restart_wr_d_gnt", 32'(bus.d_gnt), 32'd1);
    check("restart_wr_mem_wd", bus.mem_wd, 32'h0000EE77);
    tick();
    bus.d_req = 1'b0;
    check("restart_mem13", 32'(mem_arr[8'h13]), 32'h77);
    data_op(1'b0, SIZE_BYTE, 32'h13, 32'h0, 32'h00000077);
    data_op(1'b0, SIZE_WORD, 32'h10, 32'h0, 32'h77CCBEEF);

    repeat (3) tick();
    check("if_exp_drained", 32'(if_exp_q.size()), 32'd0);
    check("d_exp_drained", 32'(d_exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
